aes_round_ctrl: RTL

//  Parametrised AES round sequencer; successor to the fixed AES-128 encrypt-only FSM.

---
 rtl/aes_round_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer (encrypt/decrypt order, multi-cycle SubBytes).
// Optional AES_CTRL_STALL_EN adds a dp_ready input that freezes the sequence while low.
module aes_round_ctrl #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned SUB_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             decrypt,
`ifdef AES_CTRL_STALL_EN
  input  logic             dp_ready,
`endif
  output logic [1:0]       sel,
  output logic             add_round_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic             mix_en,
  output logic             expand_key_en,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned SubW = $clog2(SUB_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StSub,
    StShift,
    StMix,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic             dec_q, dec_d;
  logic [SubW-1:0]  sub_cnt_q, sub_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic [1:0]       sel_add;
  logic             sub_last;
  logic             ready;

`ifdef AES_CTRL_STALL_EN
  assign ready = dp_ready;
`else
  assign ready = 1'b1;
`endif

  assign sub_last = (sub_cnt_q == SubW'(SUB_CYCLES - 1));

  always_comb begin
    sel_add = 2'b10;
    if (round_q == '0) begin
      sel_add = 2'b01;
    end else if (round_q == nr_q) begin
      sel_add = 2'b11;
    end
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    nr_d      = nr_q;
    dec_d     = dec_q;
    sub_cnt_d = sub_cnt_q;
    sel_d     = sel_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle, StFinish: begin
        state_d = StIdle;
        if (start) begin
          if (key_len == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = StAdd;
            round_d = '0;
            dec_d   = decrypt;
            case (key_len)
              2'b00:   nr_d = CNT_W'(10);
              2'b01:   nr_d = CNT_W'(12);
              default: nr_d = CNT_W'(14);
            endcase
          end
        end
      end
      StAdd: begin
        if (ready) begin
          sel_d = sel_add;
          if (round_q == nr_q) begin
            state_d = StFinish;
          end else begin
            round_d = round_q + CNT_W'(1);
            if (!dec_q) begin
              state_d   = StSub;
              sub_cnt_d = '0;
            end else if (round_q == '0) begin
              state_d = StShift;
            end else begin
              // Decrypt: InvMixColumns follows AddRoundKey within the round.
              state_d = StMix;
            end
          end
        end
      end
      StSub: begin
        if (ready) begin
          if (sub_last) begin
            sub_cnt_d = '0;
            state_d   = dec_q ? StAdd : StShift;
          end else begin
            sub_cnt_d = sub_cnt_q + SubW'(1);
          end
        end
      end
      StShift: begin
        if (ready) begin
          if (dec_q) begin
            state_d   = StSub;
            sub_cnt_d = '0;
          end else if (round_q == nr_q) begin
            state_d = StAdd;
          end else begin
            state_d = StMix;
          end
        end
      end
      StMix: begin
        if (ready) begin
          state_d = dec_q ? StShift : StAdd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      round_q   <= '0;
      nr_q      <= CNT_W'(10);
      dec_q     <= 1'b0;
      sub_cnt_q <= '0;
      sel_q     <= 2'b01;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      nr_q      <= nr_d;
      dec_q     <= dec_d;
      sub_cnt_q <= sub_cnt_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  // sel tracks the round in ADD and otherwise holds the key chosen by the last ADD.
  assign sel           = (state_q == StAdd) ? sel_add : sel_q;
  assign add_round_en  = (state_q == StAdd) && ready;
  assign sub_en        = (state_q == StSub) && ready;
  assign shift_en      = (state_q == StShift) && ready;
  assign mix_en        = (state_q == StMix) && ready;
  assign expand_key_en = sub_en && (sub_cnt_q == '0);
  assign round         = round_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFinish);
  assign err           = err_q;

endmodule
